// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - seven-segment codes, BCD decoder and prescaler width helper
package seg7_pkg;

  // Active-low segment patterns {dp,g,f,e,d,c,b,a}; dp always off
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Non-decimal codes never occur in a BCD field; show them blank
  function automatic logic [7:0] bcd_to_seg(input logic [3:0] bcd);
    logic [7:0] seg;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Counter width able to hold 0 .. clk_hz/rate-1 (at least one bit)
  function automatic int div_cnt_w(input int clk_hz, input int rate);
    int n;
    int w;
    n = clk_hz / rate;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// rtl/bcd_mod_counter.sv - two-digit BCD field counting 0 .. MOD-1 with wrap carry
module bcd_mod_counter #(
  parameter int MOD_TENS  = 6,
  parameter int MOD_UNITS = 0
) (
  input  logic       clk,
  input  logic       arst_i,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] bcd,
  output logic       carry
);

  // Largest value the field shows, e.g. 59 for MOD 60 and 23 for MOD 24
  localparam logic [3:0] MAX_TENS  = (MOD_UNITS == 0) ? 4'(MOD_TENS - 1) : 4'(MOD_TENS);
  localparam logic [3:0] MAX_UNITS = (MOD_UNITS == 0) ? 4'd9 : 4'(MOD_UNITS - 1);

  logic [3:0] tens;
  logic [3:0] units;
  logic       at_max;

  assign at_max = (tens == MAX_TENS) && (units == MAX_UNITS);
  // Combinational so the next field advances on the same edge as the wrap
  assign carry  = inc && !clr && at_max;
  assign bcd    = {tens, units};

  // Field register: clear wins over increment
  always_ff @(posedge clk or posedge arst_i) begin
    if (arst_i) begin
      tens  <= 4'd0;
      units <= 4'd0;
    end else if (clr) begin
      tens  <= 4'd0;
      units <= 4'd0;
    end else if (inc) begin
      if (at_max) begin
        tens  <= 4'd0;
        units <= 4'd0;
      end else if (units == 4'd9) begin
        units <= 4'd0;
        tens  <= tens + 4'd1;
      end else begin
        units <= units + 4'd1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_display.sv
// rtl/stopwatch_display.sv - stopwatch core with adjust/blink and multiplexed 7-seg drive
module stopwatch_display
  import seg7_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int SCAN_HZ    = 500,
  parameter int ADJ_HZ     = 2,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    arst_i,
  input  logic                    pause_i,
  input  logic                    clear_i,
  input  logic                    adj_i,
  input  logic [1:0]              sel_i,
  output logic [7:0]              seg_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic [4*NUM_DIGITS-1:0] bcd_o
);

  localparam int NUM_FIELDS = NUM_DIGITS / 2;
  localparam int DIV_1S     = CLK_HZ;
  localparam int DIV_ADJ    = CLK_HZ / ADJ_HZ;
  localparam int DIV_SCAN   = CLK_HZ / SCAN_HZ;
  localparam int W_1S       = div_cnt_w(CLK_HZ, 1);
  localparam int W_ADJ      = div_cnt_w(CLK_HZ, ADJ_HZ);
  localparam int W_SCAN     = div_cnt_w(CLK_HZ, SCAN_HZ);

  if (NUM_DIGITS != 4 && NUM_DIGITS != 6) begin : g_bad_num_digits
    $error("stopwatch_display: NUM_DIGITS must be 4 or 6");
  end
  if ((CLK_HZ % SCAN_HZ) != 0 || (CLK_HZ % ADJ_HZ) != 0) begin : g_bad_rates
    $error("stopwatch_display: SCAN_HZ and ADJ_HZ must divide CLK_HZ");
  end

  logic [W_1S-1:0]   cnt_1s;
  logic [W_ADJ-1:0]  cnt_adj;
  logic [W_SCAN-1:0] cnt_scan;
  logic              tick_1s;
  logic              tick_adj;
  logic              tick_scan;

  assign tick_1s   = (cnt_1s   == W_1S'(DIV_1S - 1));
  assign tick_adj  = (cnt_adj  == W_ADJ'(DIV_ADJ - 1));
  assign tick_scan = (cnt_scan == W_SCAN'(DIV_SCAN - 1));

  // One-second prescaler; clear restarts a full second
  always_ff @(posedge clk or posedge arst_i) begin
    if (arst_i)                    cnt_1s <= '0;
    else if (clear_i || tick_1s)   cnt_1s <= '0;
    else                           cnt_1s <= cnt_1s + 1'b1;
  end

  // Adjust/blink prescaler
  always_ff @(posedge clk or posedge arst_i) begin
    if (arst_i)                    cnt_adj <= '0;
    else if (clear_i || tick_adj)  cnt_adj <= '0;
    else                           cnt_adj <= cnt_adj + 1'b1;
  end

  // Digit scan prescaler
  always_ff @(posedge clk or posedge arst_i) begin
    if (arst_i)                    cnt_scan <= '0;
    else if (clear_i || tick_scan) cnt_scan <= '0;
    else                           cnt_scan <= cnt_scan + 1'b1;
  end

  logic paused;

  // Pause pulse toggles run/hold in every mode; a same-cycle tick sees the old value
  always_ff @(posedge clk or posedge arst_i) begin
    if (arst_i)       paused <= 1'b0;
    else if (pause_i) paused <= ~paused;
  end

  logic                  run_tick;
  logic [NUM_FIELDS-1:0] field_carry;
  logic                  carry_unused;

  // Adjust mode masks the seconds tick; clear priority lives in the field counters
  assign run_tick     = tick_1s && !adj_i && !paused;
  // The top field's wrap has nowhere to go
  assign carry_unused = field_carry[NUM_FIELDS-1];

  for (genvar f = 0; f < NUM_FIELDS; f++) begin : g_field
    localparam int MT = (f == 2) ? 2 : 6;
    localparam int MU = (f == 2) ? 4 : 0;
    logic       inc;
    logic [7:0] fbcd;

    if (f == 0) begin : g_ss
      assign inc = run_tick || (adj_i && tick_adj && sel_i == 2'd0);
    end else begin : g_upper
      // Adjusted fields never ripple into their neighbours
      assign inc = adj_i ? (tick_adj && sel_i == 2'(f)) : field_carry[f-1];
    end

    bcd_mod_counter #(
      .MOD_TENS  (MT),
      .MOD_UNITS (MU)
    ) u_field (
      .clk    (clk),
      .arst_i (arst_i),
      .inc    (inc),
      .clr    (clear_i),
      .bcd    (fbcd),
      .carry  (field_carry[f])
    );

    assign bcd_o[8*f +: 8] = fbcd;
  end

  logic       blink;
  logic [1:0] blink_sel;

  // Blink phase and the field it applies to, both sampled on the adjust tick
  always_ff @(posedge clk or posedge arst_i) begin
    if (arst_i) begin
      blink     <= 1'b0;
      blink_sel <= 2'd0;
    end else if (!adj_i) begin
      blink     <= 1'b0;
    end else if (tick_adj) begin
      blink     <= ~blink;
      blink_sel <= sel_i;
    end
  end

  logic [NUM_DIGITS-1:0] blank_mask;

  // Two digits per field; sel 3 (and 2 on a four-digit build) matches nothing
  always_comb begin
    blank_mask = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (blink && (d / 2) == int'(blink_sel)) blank_mask[d] = 1'b1;
    end
  end

  logic [2:0]            scan_idx;
  logic [2:0]            idx_next;
  logic [3:0]            scan_digit;
  logic [NUM_DIGITS-1:0] an_next;
  logic [NUM_DIGITS-1:0] an_scan;
  logic [7:0]            seg_q;

  assign idx_next = (scan_idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : scan_idx + 3'd1;

  // Pick the digit and anode pattern for the slot being entered
  always_comb begin
    scan_digit = 4'd0;
    an_next    = '1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (idx_next == 3'(d)) begin
        scan_digit = bcd_o[4*d +: 4];
        an_next[d] = 1'b0;
      end
    end
  end

  // Scan register: index, anode and segment pattern move together on tick_scan
  always_ff @(posedge clk or posedge arst_i) begin
    if (arst_i) begin
      scan_idx <= 3'd0;
      an_scan  <= {{(NUM_DIGITS-1){1'b1}}, 1'b0};
      seg_q    <= SEG_0;
    end else if (tick_scan) begin
      scan_idx <= idx_next;
      an_scan  <= an_next;
      seg_q    <= bcd_to_seg(scan_digit);
    end
  end

  assign an_o  = an_scan | blank_mask;
  assign seg_o = seg_q;

endmodule

// File: tb/tb_stopwatch_display.sv
// tb/tb_stopwatch_display.sv - directed self-checking bench for stopwatch_display
module tb_stopwatch_display;

  logic        clk;
  logic        a_arst, a_pause, a_clear, a_adj;
  logic [1:0]  a_sel;
  logic [7:0]  seg4;
  logic [3:0]  an4;
  logic [15:0] bcd4;
  logic        b_arst, b_pause, b_clear, b_adj;
  logic [1:0]  b_sel;
  logic [7:0]  seg6;
  logic [5:0]  an6;
  logic [23:0] bcd6;

  int n;
  int n_checks;
  int n_pass;

  logic [3:0] blink_tab [8] = '{4'b1110, 4'b1101, 4'b1111, 4'b1111,
                                4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [3:0] an_tab    [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [7:0] seg_1234  [4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};

  stopwatch_display #(
    .CLK_HZ(8), .SCAN_HZ(8), .ADJ_HZ(2), .NUM_DIGITS(4)
  ) dut4 (
    .clk(clk), .arst_i(a_arst), .pause_i(a_pause), .clear_i(a_clear),
    .adj_i(a_adj), .sel_i(a_sel), .seg_o(seg4), .an_o(an4), .bcd_o(bcd4)
  );

  stopwatch_display #(
    .CLK_HZ(8), .SCAN_HZ(8), .ADJ_HZ(2), .NUM_DIGITS(6)
  ) dut6 (
    .clk(clk), .arst_i(b_arst), .pause_i(b_pause), .clear_i(b_clear),
    .adj_i(b_adj), .sel_i(b_sel), .seg_o(seg6), .an_o(an6), .bcd_o(bcd6)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic wait_to(input int target);
    while (n < target) tick();
  endtask

  task automatic reset4(input string tag);
    a_arst = 1'b1;
    #2;
    check({tag, "_bcd"}, 32'(bcd4), 32'h0);
    check({tag, "_an"},  32'(an4),  32'hE);
    check({tag, "_seg"}, 32'(seg4), 32'hC0);
    @(posedge clk);
    #1;
    a_arst = 1'b0;
    n = 0;
  endtask

  task automatic reset6(input string tag);
    b_arst = 1'b1;
    #2;
    check({tag, "_bcd"}, 32'(bcd6), 32'h0);
    check({tag, "_an"},  32'(an6),  32'h3E);
    check({tag, "_seg"}, 32'(seg6), 32'hC0);
    @(posedge clk);
    #1;
    b_arst = 1'b0;
    n = 0;
  endtask

  initial begin
    clk = 1'b0;
    a_arst = 1'b1; a_pause = 1'b0; a_clear = 1'b0; a_adj = 1'b0; a_sel = 2'd0;
    b_arst = 1'b1; b_pause = 1'b0; b_clear = 1'b0; b_adj = 1'b0; b_sel = 2'd0;
    n = 0; n_checks = 0; n_pass = 0;
    #1;

    // run, carry and full rollover
    reset4("rst");
    wait_to(472);     check("run_0059", 32'(bcd4), 32'h0059);
    wait_to(479);     check("run_0059_edge", 32'(bcd4), 32'h0059);
    wait_to(480);     check("run_0100", 32'(bcd4), 32'h0100);
    wait_to(8*3599);  check("run_5959", 32'(bcd4), 32'h5959);
    wait_to(8*3600);  check("rollover", 32'(bcd4), 32'h0000);

    // pause / resume, pause coincident with tick_1s
    wait_to(28804); a_pause = 1'b1; tick(); a_pause = 1'b0;
    wait_to(28848); check("paused_hold", 32'(bcd4), 32'h0000);
    a_pause = 1'b1; tick(); a_pause = 1'b0;
    wait_to(28855); check("resume_pre", 32'(bcd4), 32'h0000);
    wait_to(28856); check("resume_1s", 32'(bcd4), 32'h0001);
    wait_to(28863); a_pause = 1'b1; tick(); a_pause = 1'b0;
    check("pause_on_tick", 32'(bcd4), 32'h0002);
    wait_to(28880); check("pause_after", 32'(bcd4), 32'h0002);

    // adjust, blink and no-carry wrap
    reset4("rst_adj");
    a_adj = 1'b1; a_sel = 2'd0;
    wait_to(232); check("adj_ss58", 32'(bcd4), 32'h0058);
    a_sel = 2'd1;
    for (int k = 236; k < 244; k++) begin
      wait_to(k);
      check("blink_mm_an", 32'(an4), 32'(blink_tab[k-236]));
    end
    wait_to(244); check("adj_0358", 32'(bcd4), 32'h0358);
    a_sel = 2'd0;
    wait_to(248); check("adj_0359", 32'(bcd4), 32'h0359);
    wait_to(252); check("adj_ss_wrap", 32'(bcd4), 32'h0300);
    check("blink_ss_an", 32'(an4), 32'hF);
    a_adj = 1'b0;
    wait_to(253); check("blink_off_an", 32'(an4), 32'hD);
    wait_to(255); check("post_adj_pre", 32'(bcd4), 32'h0300);
    wait_to(256); check("post_adj_1s", 32'(bcd4), 32'h0301);

    // scan sequence at a held 12:34
    reset4("rst_scan");
    a_pause = 1'b1; a_adj = 1'b1; a_sel = 2'd0;
    tick(); a_pause = 1'b0;
    wait_to(136); a_sel = 2'd1;
    wait_to(184); check("preload_1234", 32'(bcd4), 32'h1234);
    a_adj = 1'b0;
    for (int k = 185; k < 193; k++) begin
      wait_to(k);
      check("scan_an",  32'(an4),  32'(an_tab[k % 4]));
      check("scan_seg", 32'(seg4), 32'(seg_1234[k % 4]));
    end
    wait_to(200); check("hold_1234", 32'(bcd4), 32'h1234);

    // reset mid-count, then sel=2 selecting nothing, then reset mid-adjust
    reset4("rst_mid_count");
    a_adj = 1'b1; a_sel = 2'd2;
    wait_to(12); check("sel2_none", 32'(bcd4), 32'h0000);
    a_sel = 2'd0;
    wait_to(40); check("adj_ss07", 32'(bcd4), 32'h0007);
    reset4("rst_mid_adj");
    a_adj = 1'b0;

    // clear coincident with tick_1s, clear restarting the prescaler
    wait_to(23); check("pre_clear", 32'(bcd4), 32'h0002);
    a_clear = 1'b1; tick(); a_clear = 1'b0;
    check("clear_on_tick", 32'(bcd4), 32'h0000);
    wait_to(31); check("clear_pre_1s", 32'(bcd4), 32'h0000);
    wait_to(32); check("clear_1s", 32'(bcd4), 32'h0001);
    wait_to(36); a_clear = 1'b1; tick(); a_clear = 1'b0;
    wait_to(41); check("presc_restart", 32'(bcd4), 32'h0000);
    wait_to(44); check("presc_pre", 32'(bcd4), 32'h0000);
    wait_to(45); check("presc_1s", 32'(bcd4), 32'h0001);

    // six-digit build: preload 23:59:59 and roll over
    reset6("rst6");
    b_adj = 1'b1; b_sel = 2'd0;
    wait_to(236); check("adj6_ss", 32'(bcd6), 32'h000059);
    b_sel = 2'd1;
    wait_to(472); check("adj6_mm", 32'(bcd6), 32'h005959);
    b_sel = 2'd2;
    wait_to(564); check("adj6_hh", 32'(bcd6), 32'h235959);
    b_adj = 1'b0;
    wait_to(567); check("roll6_pre", 32'(bcd6), 32'h235959);
    wait_to(568); check("roll6", 32'(bcd6), 32'h000000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
